alu_sequencer: RTL

- Multi-cycle control sequencer for the 10-bit datapath.
- Latches one instruction word and steps the shared-bus datapath through its micro-operations: register-file read/write strobes, external-input drive, ALU operand loads (Ain/Gin), ALU function select (FN), ALU result capture (Gout) and result-to-bus drive.
- Sits directly upstream of the ALU and drives all of that block's control inputs.

---
 rtl/alu_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer: latches one instruction and steps the shared-bus ALU datapath.
// Latency from the accepting edge to the end of DONE: binary ALU 4, unary ALU 3, LDI/MOV/NOP 1.
// EXEC is accepted only in IDLE; requests and INSTR changes while BUSY are ignored.
module alu_sequencer #(
  parameter int NREG = 4,
  parameter int IW   = 10
) (
  input  logic            CLKb,
  input  logic            RST,
  input  logic [IW-1:0]   INSTR,
  input  logic            EXEC,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            ExtOut,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [3:0]      FN,
  output logic            ALUout,
  output logic            BUSY,
  output logic            DONE
);

  // Instruction field layout: opcode on top, then Rx, then Ry, low bits unused.
  localparam int RW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int OP_LSB = IW - 4;
  localparam int RX_LSB = OP_LSB - RW;
  localparam int RY_LSB = RX_LSB - RW;

  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_MOV = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXE,
    WB
  } state_t;

  // Full set of registered control outputs, updated as one word.
  typedef struct packed {
    logic [NREG-1:0] rin;
    logic [NREG-1:0] rout;
    logic            ext;
    logic            ain;
    logic            gin;
    logic            gout;
    logic [3:0]      fn;
    logic            aluout;
    logic            busy;
    logic            done;
  } ctrl_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ir;
  logic [IW-1:0] ir_nxt;
  ctrl_t         ctrl;
  ctrl_t         ctrl_nxt;

  // ALU opcodes occupy 0010..1011; 0100 (inv) and 0101 (flp) take only the B operand.
  function automatic logic is_alu(input logic [3:0] op);
    return (op >= 4'b0010) && (op <= 4'b1011);
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b0101);
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
    return NREG'(1) << idx;
  endfunction

  // Next-state and instruction-register capture; IR only loads on acceptance from IDLE.
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    case (state)
      IDLE: begin
        if (EXEC) begin
          ir_nxt = INSTR;
          if (is_alu(INSTR[IW-1 -: 4]) && !is_unary(INSTR[IW-1 -: 4])) begin
            state_nxt = RD_A;
          end else if (is_unary(INSTR[IW-1 -: 4])) begin
            state_nxt = RD_B;
          end else begin
            state_nxt = WB;
          end
        end
      end
      RD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = EXE;
      EXE:     state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decode the outputs of the state being entered so they appear registered with it.
  always_comb begin
    logic [3:0]    op;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    op       = ir_nxt[IW-1 -: 4];
    rx       = ir_nxt[RX_LSB +: RW];
    ry       = ir_nxt[RY_LSB +: RW];
    ctrl_nxt = '0;
    ctrl_nxt.busy = (state_nxt != IDLE);
    case (state_nxt)
      RD_A: begin
        ctrl_nxt.rout = onehot(rx);
        ctrl_nxt.ain  = 1'b1;
      end
      RD_B: begin
        ctrl_nxt.rout = onehot(ry);
        ctrl_nxt.gin  = 1'b1;
      end
      EXE: begin
        ctrl_nxt.gout = 1'b1;
        ctrl_nxt.fn   = op;
      end
      WB: begin
        ctrl_nxt.done = 1'b1;
        if (is_alu(op)) begin
          ctrl_nxt.aluout = 1'b1;
          ctrl_nxt.rin    = onehot(rx);
        end else if (op == OP_LDI) begin
          ctrl_nxt.ext = 1'b1;
          ctrl_nxt.rin = onehot(rx);
        end else if (op == OP_MOV) begin
          // Rx == Ry is legal: the register drives and captures its own value.
          ctrl_nxt.rout = onehot(ry);
          ctrl_nxt.rin  = onehot(rx);
        end
      end
      default: ctrl_nxt = '0;
    endcase
  end

  // Falling-edge state, IR and output registers; reset aborts any instruction at once.
  always_ff @(negedge CLKb or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ir    <= '0;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      ctrl  <= ctrl_nxt;
    end
  end

  assign Rin    = ctrl.rin;
  assign Rout   = ctrl.rout;
  assign ExtOut = ctrl.ext;
  assign Ain    = ctrl.ain;
  assign Gin    = ctrl.gin;
  assign Gout   = ctrl.gout;
  assign FN     = ctrl.fn;
  assign ALUout = ctrl.aluout;
  assign BUSY   = ctrl.busy;
  assign DONE   = ctrl.done;

endmodule
